// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: receiver FSM states, character width
//               and bit-period arithmetic for the RX and TX paths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_t;

    // Clock cycles per serial bit, truncated.
    function automatic int uart_bit_ticks(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

    function automatic int uart_half_ticks(input int clock_freq, input int baud_rate);
        return uart_bit_ticks(clock_freq, baud_rate) / 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock show-ahead FIFO with registered occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int                c_PTR_W   = $clog2(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_PTR_W:0]   c_CNT_ONE = (c_PTR_W + 1)'(1);
    localparam logic [c_PTR_W:0]   c_FULL    = (c_PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign empty = (r_count == '0);
    assign full  = (r_count == c_FULL);
    assign count = r_count;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    assign dout = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_rx_buffer.sv
// ============================================================================
// Module      : uart_rx_buffer
// Description : UART 8N1 receiver with input synchronizer, deframing FSM,
//               sticky error flags and a show-ahead receive FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DEPTH      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     serial_in,
    output logic [7:0]               data_out,
    output logic                     data_out_valid,
    input  logic                     data_out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     framing_error,
    input  logic                     err_clear
);

    localparam int c_BIT_T  = uart_bit_ticks(CLOCK_FREQ, BAUD_RATE);
    localparam int c_HALF_T = uart_half_ticks(CLOCK_FREQ, BAUD_RATE);
    localparam int c_CNT_W  = $clog2(c_BIT_T) + 1;
    localparam int c_IDX_W  = $clog2(UART_DATA_BITS);

    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(c_BIT_T - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(c_HALF_T - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(UART_DATA_BITS - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE   = c_IDX_W'(1);

    logic                      r_sync1;
    logic                      r_rx_s;
    rx_state_t                 r_state;
    rx_state_t                 w_state_next;
    logic [c_CNT_W-1:0]        r_tick;
    logic [c_CNT_W-1:0]        w_tick_next;
    logic [c_IDX_W-1:0]        r_bit_idx;
    logic [c_IDX_W-1:0]        w_bit_idx_next;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [UART_DATA_BITS-1:0] w_shift_next;
    logic                      w_push;
    logic                      w_frame_err;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_drop;
    logic                      r_overflow;
    logic                      r_framing_error;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= serial_in;
            r_rx_s  <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RX_IDLE;
            r_tick    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_tick    <= w_tick_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_tick_next    = r_tick + c_CNT_ONE;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_push         = 1'b0;
        w_frame_err    = 1'b0;
        case (r_state)
            RX_IDLE: begin
                w_tick_next = '0;
                if (!r_rx_s) begin
                    w_state_next = RX_START;
                end
            end
            RX_START: begin
                // Mid-start-bit recheck rejects short glitches.
                if (r_tick == c_HALF_LAST) begin
                    w_tick_next = '0;
                    if (r_rx_s) begin
                        w_state_next = RX_IDLE;
                    end else begin
                        w_state_next   = RX_DATA;
                        w_bit_idx_next = '0;
                    end
                end
            end
            RX_DATA: begin
                if (r_tick == c_BIT_LAST) begin
                    w_tick_next  = '0;
                    w_shift_next = {r_rx_s, r_shift[UART_DATA_BITS-1:1]};
                    if (r_bit_idx == c_IDX_LAST) begin
                        w_state_next = RX_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + c_IDX_ONE;
                    end
                end
            end
            RX_STOP: begin
                if (r_tick == c_BIT_LAST) begin
                    w_tick_next = '0;
                    if (r_rx_s) begin
                        w_push       = 1'b1;
                        w_state_next = RX_IDLE;
                    end else begin
                        w_frame_err  = 1'b1;
                        w_state_next = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                // Do not resynchronize while the line is held in a break.
                w_tick_next = '0;
                if (r_rx_s) begin
                    w_state_next = RX_IDLE;
                end
            end
            default: begin
                w_tick_next  = '0;
                w_state_next = RX_IDLE;
            end
        endcase
    end

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (w_shift_next),
        .pop   (data_out_ready),
        .dout  (data_out),
        .count (count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign data_out_valid = !w_empty;
    assign w_drop         = w_push && w_full && !data_out_ready;

    // Set events take priority over a coincident clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow      <= 1'b0;
            r_framing_error <= 1'b0;
        end else begin
            r_overflow      <= w_drop || (r_overflow && !err_clear);
            r_framing_error <= w_frame_err || (r_framing_error && !err_clear);
        end
    end

    assign overflow      = r_overflow;
    assign framing_error = r_framing_error;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_buffer.sv
// ============================================================================
// Module      : tb_uart_rx_buffer
// Description : Self-checking bench for uart_rx_buffer with a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_buffer;

    localparam int c_CF    = 1000;
    localparam int c_BR    = 100;
    localparam int c_DEPTH = 4;
    localparam int c_BIT_T = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       serial_in = 1'b1;
    logic       data_out_ready = 1'b0;
    logic       err_clear = 1'b0;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic [2:0] count;
    logic       overflow;
    logic       framing_error;

    uart_rx_buffer #(
        .CLOCK_FREQ (c_CF),
        .BAUD_RATE  (c_BR),
        .DEPTH      (c_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .serial_in      (serial_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .count          (count),
        .overflow       (overflow),
        .framing_error  (framing_error),
        .err_clear      (err_clear)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a received frame lands in the FIFO 98 edges after its start edge.
    typedef struct {
        int         stamp;
        logic [7:0] b;
        bit         ok;
    } ev_t;

    logic [7:0] m_q[$];
    ev_t        m_ev[$];
    bit         m_ovf = 1'b0;
    bit         m_fe  = 1'b0;
    int         cyc   = 0;

    always @(posedge clk) begin : model
        bit         was_full;
        bit         pop_now;
        bit         have_push;
        bit         set_ovf;
        bit         set_fe;
        logic [7:0] pb;
        if (rst) begin
            m_q.delete();
            m_ev.delete();
            m_ovf = 1'b0;
            m_fe  = 1'b0;
        end else begin
            was_full  = (m_q.size() == c_DEPTH);
            pop_now   = data_out_ready && (m_q.size() > 0);
            have_push = 1'b0;
            set_ovf   = 1'b0;
            set_fe    = 1'b0;
            pb        = 8'h00;
            while (m_ev.size() > 0 && m_ev[0].stamp == cyc) begin
                if (m_ev[0].ok) begin
                    have_push = 1'b1;
                    pb        = m_ev[0].b;
                end else begin
                    set_fe = 1'b1;
                end
                void'(m_ev.pop_front());
            end
            if (pop_now) void'(m_q.pop_front());
            if (have_push) begin
                if (!was_full || pop_now) m_q.push_back(pb);
                else set_ovf = 1'b1;
            end
            if (err_clear) begin
                m_ovf = 1'b0;
                m_fe  = 1'b0;
            end
            m_ovf = m_ovf | set_ovf;
            m_fe  = m_fe | set_fe;
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            check("cmp_valid", data_out_valid, m_q.size() > 0);
            check("cmp_count", count, m_q.size());
            if (m_q.size() > 0) check("cmp_data", data_out, m_q[0]);
            check("cmp_overflow", overflow, m_ovf);
            check("cmp_framing", framing_error, m_fe);
        end
    end

    // All driving tasks start and end 1 time unit after a rising edge.
    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int extra_low);
        ev_t e;
        e.stamp = cyc + 97;
        e.b     = b;
        e.ok    = stop_ok;
        m_ev.push_back(e);
        serial_in = 1'b0;
        hold(c_BIT_T);
        for (int i = 0; i < 8; i++) begin
            serial_in = b[i];
            hold(c_BIT_T);
        end
        serial_in = stop_ok;
        hold(c_BIT_T);
        if (extra_low > 0) begin
            serial_in = 1'b0;
            hold(extra_low);
        end
        serial_in = 1'b1;
    endtask

    task automatic pop_expect(input logic [7:0] exp);
        check("pop_valid", data_out_valid, 1'b1);
        check("pop_data", data_out, exp);
        data_out_ready = 1'b1;
        hold(1);
        data_out_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        hold(3);
        rst = 1'b0;
        check("reset_valid", data_out_valid, 1'b0);
        check("reset_count", count, 3'd0);
        check("reset_data", data_out, 8'h00);
        check("reset_overflow", overflow, 1'b0);
        check("reset_framing", framing_error, 1'b0);
        hold(5);

        // Single byte with exact arrival latency.
        fork
            send_frame(8'hA5, 1'b1, 0);
            begin
                hold(97);
                check("lat_before", data_out_valid, 1'b0);
                hold(1);
                check("lat_at_98", data_out_valid, 1'b1);
                check("single_data", data_out, 8'hA5);
                check("single_count", count, 3'd1);
            end
        join
        pop_expect(8'hA5);
        check("single_count_after_pop", count, 3'd0);
        hold(5);

        // Short glitch is rejected.
        serial_in = 1'b0;
        hold(3);
        serial_in = 1'b1;
        hold(20);
        check("glitch_count", count, 3'd0);
        send_frame(8'h3C, 1'b1, 0);
        pop_expect(8'h3C);
        hold(5);

        // Framing error with the line held low afterward.
        send_frame(8'h55, 1'b0, 30);
        check("fe_flag", framing_error, 1'b1);
        check("fe_count", count, 3'd0);
        hold(5);
        send_frame(8'h12, 1'b1, 0);
        pop_expect(8'h12);
        err_clear = 1'b1;
        hold(1);
        err_clear = 1'b0;
        check("fe_cleared", framing_error, 1'b0);
        hold(5);

        // Overflow: five back-to-back frames into a four-entry FIFO.
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 0);
        check("ovf_count", count, 3'd4);
        check("ovf_flag", overflow, 1'b1);
        for (int i = 1; i <= 4; i++) pop_expect(8'(i));
        check("ovf_drained", count, 3'd0);
        err_clear = 1'b1;
        hold(1);
        err_clear = 1'b0;
        check("ovf_cleared", overflow, 1'b0);
        hold(5);

        // Full FIFO: pop coincides with the stop sample of 0x06.
        for (int i = 2; i <= 5; i++) send_frame(8'(i), 1'b1, 0);
        check("full_count_pre", count, 3'd4);
        fork
            send_frame(8'h06, 1'b1, 0);
            begin
                hold(97);
                data_out_ready = 1'b1;
                hold(1);
                data_out_ready = 1'b0;
            end
        join
        check("full_count", count, 3'd4);
        check("full_no_ovf", overflow, 1'b0);
        for (int i = 3; i <= 6; i++) pop_expect(8'(i));
        hold(5);

        // Reset in the middle of a character, with a byte already queued.
        send_frame(8'h11, 1'b1, 0);
        serial_in = 1'b0;
        hold(40);
        rst       = 1'b1;
        serial_in = 1'b1;
        hold(1);
        rst = 1'b0;
        check("midrst_valid", data_out_valid, 1'b0);
        check("midrst_count", count, 3'd0);
        check("midrst_data", data_out, 8'h00);
        check("midrst_overflow", overflow, 1'b0);
        check("midrst_framing", framing_error, 1'b0);
        hold(20);
        send_frame(8'h7E, 1'b1, 0);
        pop_expect(8'h7E);
        hold(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx_buffer.md
# uart_rx_buffer

Receive path of the memory-mapped UART: it oversamples the asynchronous serial line, deframes 8N1 characters and queues the bytes in a small show-ahead FIFO. The processor's I/O decode logic drains the FIFO through a valid/ready interface, polling `data_out_valid` as the receive-ready status bit and reading `data_out`. The FIFO decouples character arrival from CPU stalls and polling latency.

## Interface
Parameters:
- `CLOCK_FREQ`, 50_000_000: clock frequency in Hz.
- `BAUD_RATE`, 115_200: line rate in bits per second.
- `DEPTH`, 8: FIFO entries; must be a power of two, at least 2.

Ports:
- `clk` in 1: single clock; all logic is clocked on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `serial_in` in 1: asynchronous RX line; idles high.
- `data_out` out 8: byte at the FIFO head; valid only while `data_out_valid` is high.
- `data_out_valid` out 1: FIFO is not empty.
- `data_out_ready` in 1: consumer takes the head byte this cycle.
- `count` out $clog2(DEPTH)+1: current FIFO occupancy.
- `overflow` out 1: sticky; a byte was dropped because the FIFO was full.
- `framing_error` out 1: sticky; a character had a low stop bit.
- `err_clear` in 1: clears both sticky flags.

## Operation
- **Synchronizer:** `serial_in` passes through 2 flops, both reset to 1. All logic below uses the synchronized line `rx_s`.
- **Timing constants:** `BIT_T = CLOCK_FREQ/BAUD_RATE` (integer division) and `HALF_T = BIT_T/2`. A single tick counter is sized `$clog2(BIT_T)+1` bits.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH.
  - **IDLE:** `rx_s == 0` → START, counter cleared.
  - **START:** at count `HALF_T-1`, sample `rx_s`. If it is 1 (glitch/false start) → IDLE. If it is 0 → DATA with bit index 0, counter cleared.
  - **DATA:** every `BIT_T` ticks, sample `rx_s` into the shift register, LSB first. After bit 7 → STOP.
  - **STOP:** after `BIT_T` ticks, sample `rx_s`.
    - 1: push the byte and go to IDLE.
    - 0: set `framing_error`, discard the byte, go to WAIT_HIGH.
  - **WAIT_HIGH:** stay until `rx_s == 1`, then → IDLE. This avoids resyncing inside a break condition.
- **FIFO:** circular buffer with pointers of width `$clog2(DEPTH)` that wrap naturally. `count` is a registered occupancy.
  - Pop occurs when `data_out_valid && data_out_ready`.
  - Push while full (without a simultaneous pop) drops the new byte, sets `overflow` and leaves stored data unchanged.
  - Push and pop in the same cycle when full: both take effect and `count` stays at `DEPTH`.
  - Push and pop in the same cycle when empty: the pop is ignored (`data_out_valid` is 0) and the push proceeds.
- **Sticky flags:** `err_clear` clears `overflow` and `framing_error`. If a set event and `err_clear` occur in the same cycle, the set wins.
- **Reset:** everything returns to its reset value in one cycle, including mid-character; a partial byte is discarded.
  - FSM = IDLE; pointers, `count`, `overflow`, `framing_error` = 0; `data_out_valid` = 0; `data_out` = 0.
  - If the line is low when reset releases, the receiver treats it as a start edge.

## Timing
- Synchronizer latency is 2 cycles.
- The push happens on the edge that takes the stop sample. `data_out_valid` rises on the following cycle.
- End-to-end latency from the falling edge of `serial_in` to `data_out_valid` is 2 + `HALF_T` + 9×`BIT_T` + 1 cycles, within ±1 cycle of sampling phase.
- `data_out` is combinationally driven from the head entry and changes the cycle after a pop.
- Throughput is back-to-back characters at line rate with no gaps required. The FSM re-arms in IDLE the cycle after the stop sample, half a bit before the nominal next start edge.
- No combinational path exists from `data_out_ready` to `data_out_valid`.

## Structure
- **Shared package `uart_pkg`:** FSM state enum `rx_state_t`, `UART_DATA_BITS = 8`, and the `BIT_T`/`HALF_T` calculation as a function. The TX block reuses these.
- **Sub-module `sync_fifo`:** parameterized by `WIDTH` and `DEPTH`, with ports `push`/`din`/`pop`/`dout`/`count`/`full`/`empty`. It is also reused by the TX path.
- **Top level:** synchronizer, tick counter, FSM and sticky flags.

## Test plan
All scenarios use `CLOCK_FREQ=1000`, `BAUD_RATE=100` (`BIT_T=10`, `HALF_T=5`) and `DEPTH=4`.
- **Single byte:** drive 0xA5 in 8N1 → `data_out_valid` rises exactly 2+5+90+1 = 98 cycles after the start edge, `data_out = 0xA5`, `count = 1`. A pop then returns `count` to 0.
- **False start:** 3-cycle low glitch → no push, FSM returns to IDLE, and a following 0x3C is received correctly.
- **Framing error:** send 0x55 with stop bit = 0 and hold the line low for 30 cycles → `framing_error = 1`, `count = 0`. After the line returns high, 0x12 is received. Asserting `err_clear` clears the flag.
- **Overflow:** 5 back-to-back bytes 0x01–0x05 with `ready = 0` → `count = 4`, `overflow = 1`, and pops return 0x01–0x04 in order.
- **Full push/pop:** with FIFO full, pop in the same cycle as the 0x06 stop sample → `count` stays 4, `overflow` stays 0, and 0x06 is last out.
- **Mid-character reset:** assert `rst` for 1 cycle mid-DATA → all outputs 0 next cycle, and the next full frame 0x7E is received correctly.
